// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Issues one instruction-memory request at a time from the PC register value,
// computes the PC register's next value every cycle (hold, +4 or redirect)
// and presents fetched instructions to decode through a registered valid/ready slot.
// Optional build macro FETCH_PERF_EN adds a free-running fetch_count output
// that counts decode handshakes.
//
// state | meaning
// REQ   | request valid for pc_cur; waiting for memory to accept
// WAIT  | one request outstanding; response goes to the slot or the hold buffer
// HOLD  | response parked in the hold buffer until decode frees the slot
// DROP  | a redirect orphaned the outstanding request; discard its response
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        accept;
    logic        rsp_to_slot;
    logic        rsp_to_hold;
    logic        hold_to_slot;
    logic        flush;

    // Request address is always the word-aligned current PC.
    assign imem_req_addr = pc_cur & ~32'h3;

    // Next-state, request valid, next PC and datapath strobes.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        pc_next        = pc_cur;
        accept         = 1'b0;
        rsp_to_slot    = 1'b0;
        rsp_to_hold    = 1'b0;
        hold_to_slot   = 1'b0;
        flush          = 1'b0;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            flush   = 1'b1;
            pc_next = redirect_pc & ~32'h3;
            if ((state == WAIT || state == DROP) && !imem_rsp_valid)
                state_nxt = DROP;
            else
                state_nxt = REQ;
        end else begin
            case (state)
                REQ: begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        accept    = 1'b1;
                        pc_next   = pc_cur + 32'd4;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!id_valid || id_ready) begin
                            rsp_to_slot = 1'b1;
                            state_nxt   = REQ;
                        end else begin
                            rsp_to_hold = 1'b1;
                            state_nxt   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        hold_to_slot = 1'b1;
                        state_nxt    = REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid)
                        state_nxt = REQ;
                end
                default: state_nxt = REQ;
            endcase
        end
    end

    // State register, request PC, decode slot and hold buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            req_pc     <= 32'h0;
            id_valid   <= 1'b0;
            id_instr   <= 32'h0;
            id_pc      <= 32'h0;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept)
                req_pc <= pc_cur & ~32'h3;
            if (flush) begin
                id_valid <= 1'b0;
            end else if (rsp_to_slot) begin
                id_valid <= 1'b1;
                id_instr <= imem_rsp_data;
                id_pc    <= req_pc;
            end else if (hold_to_slot) begin
                id_valid <= 1'b1;
                id_instr <= hold_instr;
                id_pc    <= hold_pc;
            end else if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
            if (flush) begin
                hold_instr <= 32'h0;
                hold_pc    <= 32'h0;
            end else if (rsp_to_hold) begin
                hold_instr <= imem_rsp_data;
                hold_pc    <= req_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Count every decode handshake; redirects leave the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= 32'h0;
        else if (id_valid && id_ready)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit with a PC register
// model and a one-request memory whose response can be stalled.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    logic        rsp_stall;
    logic        mem_pend;
    logic [31:0] mem_addr;

    int n_total = 0;
    int n_pass  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // PC register: loads pc_next on every clock.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_cur <= 32'h0;
        else       pc_cur <= pc_next;
    end

    // Memory: answers the accepted request next cycle unless stalled;
    // data is the address tagged so each word is identifiable.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_pend <= 1'b0;
            mem_addr <= 32'h0;
        end else begin
            if (imem_rsp_valid) mem_pend <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                mem_pend <= 1'b1;
                mem_addr <= imem_req_addr;
            end
        end
    end
    assign imem_rsp_valid = mem_pend && !rsp_stall;
    assign imem_rsp_data  = mem_addr ^ 32'hDEAD_0000;

    typedef struct packed {
        logic        rdy;
        logic        stall;
        logic        idr;
        logic        rv;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] enext;
        logic        eidv;
        logic [31:0] eidpc;
        logic [31:0] einstr;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rdy, stall, idr, rv, input logic [31:0] rpc,
                                input logic ereq, input logic [31:0] eaddr, enext,
                                input logic eidv, input logic [31:0] eidpc, einstr);
        vec_t v;
        v.rdy = rdy; v.stall = stall; v.idr = idr; v.rv = rv; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.enext = enext;
        v.eidv = eidv; v.eidpc = eidpc; v.einstr = einstr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        // c0..c7: back-to-back fetch from reset, addresses 0,4,8,C
        vecs[0]  = mk(1,0,1,0,32'h0,   1,32'h0,  32'h4,  0,32'h0, 32'h0);
        vecs[1]  = mk(1,0,1,0,32'h0,   0,32'h4,  32'h4,  0,32'h0, 32'h0);
        vecs[2]  = mk(1,0,1,0,32'h0,   1,32'h4,  32'h8,  1,32'h0, 32'hDEAD_0000);
        vecs[3]  = mk(1,0,1,0,32'h0,   0,32'h8,  32'h8,  0,32'h0, 32'hDEAD_0000);
        vecs[4]  = mk(1,0,1,0,32'h0,   1,32'h8,  32'hC,  1,32'h4, 32'hDEAD_0004);
        vecs[5]  = mk(1,0,1,0,32'h0,   0,32'hC,  32'hC,  0,32'h4, 32'hDEAD_0004);
        vecs[6]  = mk(1,0,1,0,32'h0,   1,32'hC,  32'h10, 1,32'h8, 32'hDEAD_0008);
        vecs[7]  = mk(1,0,1,0,32'h0,   0,32'h10, 32'h10, 0,32'h8, 32'hDEAD_0008);
        // c8..c12: memory not ready for 3 cycles at 0x10
        vecs[8]  = mk(0,0,1,0,32'h0,   1,32'h10, 32'h10, 1,32'hC, 32'hDEAD_000C);
        vecs[9]  = mk(0,0,1,0,32'h0,   1,32'h10, 32'h10, 0,32'hC, 32'hDEAD_000C);
        vecs[10] = mk(0,0,1,0,32'h0,   1,32'h10, 32'h10, 0,32'hC, 32'hDEAD_000C);
        vecs[11] = mk(1,0,1,0,32'h0,   1,32'h10, 32'h14, 0,32'hC, 32'hDEAD_000C);
        vecs[12] = mk(1,0,1,0,32'h0,   0,32'h14, 32'h14, 0,32'hC, 32'hDEAD_000C);
        // c13..c17: decode stalls, response for 0x14 parked in HOLD
        vecs[13] = mk(1,0,0,0,32'h0,   1,32'h14, 32'h18, 1,32'h10,32'hDEAD_0010);
        vecs[14] = mk(1,0,0,0,32'h0,   0,32'h18, 32'h18, 1,32'h10,32'hDEAD_0010);
        vecs[15] = mk(1,0,0,0,32'h0,   0,32'h18, 32'h18, 1,32'h10,32'hDEAD_0010);
        vecs[16] = mk(1,0,1,0,32'h0,   0,32'h18, 32'h18, 1,32'h10,32'hDEAD_0010);
        vecs[17] = mk(1,0,1,0,32'h0,   1,32'h18, 32'h1C, 1,32'h14,32'hDEAD_0014);
        // c18..c21: redirect to 0x103 while waiting for 0x18, response dropped
        vecs[18] = mk(1,1,1,1,32'h103, 0,32'h1C, 32'h100,0,32'h14,32'hDEAD_0014);
        vecs[19] = mk(1,0,1,0,32'h0,   0,32'h100,32'h100,0,32'h14,32'hDEAD_0014);
        vecs[20] = mk(1,0,1,0,32'h0,   1,32'h100,32'h104,0,32'h14,32'hDEAD_0014);
        vecs[21] = mk(1,0,1,0,32'h0,   0,32'h104,32'h104,0,32'h14,32'hDEAD_0014);
        // c22..c26: redirect coincident with response
        vecs[22] = mk(1,0,0,0,32'h0,   1,32'h104,32'h108,1,32'h100,32'hDEAD_0100);
        vecs[23] = mk(1,0,0,1,32'h200, 0,32'h108,32'h200,1,32'h100,32'hDEAD_0100);
        vecs[24] = mk(1,0,1,0,32'h0,   1,32'h200,32'h204,0,32'h100,32'hDEAD_0100);
        vecs[25] = mk(1,0,1,0,32'h0,   0,32'h204,32'h204,0,32'h100,32'hDEAD_0100);
        vecs[26] = mk(0,0,1,0,32'h0,   1,32'h204,32'h204,1,32'h200,32'hDEAD_0200);
        // c27..c30: redirect in REQ to unaligned top address, +4 wraps to 0
        vecs[27] = mk(1,0,1,1,32'hFFFF_FFFF, 0,32'h204,32'hFFFF_FFFC,0,32'h200,32'hDEAD_0200);
        vecs[28] = mk(1,0,1,0,32'h0,   1,32'hFFFF_FFFC,32'h0,0,32'h200,32'hDEAD_0200);
        vecs[29] = mk(1,0,0,0,32'h0,   0,32'h0,  32'h0,  0,32'h200,32'hDEAD_0200);
        vecs[30] = mk(0,0,0,0,32'h0,   1,32'h0,  32'h0,  1,32'hFFFF_FFFC,32'h2152_FFFC);

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_stall      = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst pc_next",   pc_next,                 32'h0);
        chk("rst req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst id_valid",  {31'h0, id_valid},       32'h0);
        chk("rst id_instr",  id_instr,                32'h0);
        chk("rst id_pc",     id_pc,                   32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            imem_req_ready = vecs[i].rdy;
            rsp_stall      = vecs[i].stall;
            id_ready       = vecs[i].idr;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #4;
            chk($sformatf("v%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, vecs[i].ereq});
            chk($sformatf("v%0d req_addr", i),  imem_req_addr, vecs[i].eaddr);
            chk($sformatf("v%0d pc_next", i),   pc_next,       vecs[i].enext);
            chk($sformatf("v%0d id_valid", i),  {31'h0, id_valid}, {31'h0, vecs[i].eidv});
            chk($sformatf("v%0d id_pc", i),     id_pc,         vecs[i].eidpc);
            chk($sformatf("v%0d id_instr", i),  id_instr,      vecs[i].einstr);
            @(posedge clk); #1;
        end

`ifdef FETCH_PERF_EN
        chk("fetch_count", fetch_count, 32'd7);
`endif

        // Reset asserted mid-WAIT with a stalled response outstanding.
        imem_req_ready = 1'b1;
        rsp_stall      = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        #4;
        chk("mw accept pc_next", pc_next, 32'h4);
        @(posedge clk); #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        reset          = 1'b1;
        #1;
        chk("mw rst pc_next",   pc_next,                 32'h0);
        chk("mw rst req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("mw rst id_valid",  {31'h0, id_valid},       32'h0);
        chk("mw rst id_pc",     id_pc,                   32'h0);
        chk("mw rst id_instr",  id_instr,                32'h0);
`ifdef FETCH_PERF_EN
        chk("mw rst fetch_count", fetch_count, 32'h0);
`endif
        @(posedge clk); #1;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        rsp_stall      = 1'b0;
        #3;
        chk("post rst req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("post rst req_addr",  imem_req_addr,           32'h0);
        chk("post rst pc_next",   pc_next,                 32'h0);
        chk("post rst id_valid",  {31'h0, id_valid},       32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
